// File: rtl/qupls_alu_div_seq.sv
// Sequential radix-2 restoring integer divider for the ALU reservation station.
// One quotient bit per clock; the result is held for the writeback arbiter until wr_ack.
module qupls_alu_div_seq #(
    parameter int WID   = 64,
    parameter int RNDXW = 5,
    parameter int PREGW = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             div,
    input  logic             sgn,
    input  logic [RNDXW-1:0] id,
    input  logic [PREGW-1:0] nRt,
    input  logic [WID-1:0]   argA,
    input  logic [WID-1:0]   argB,
    input  logic             flush,
    input  logic             wr_ack,
    output logic             idle,
    output logic             res_v,
    output logic [RNDXW-1:0] res_id,
    output logic [PREGW-1:0] res_nRt,
    output logic [WID-1:0]   quot,
    output logic [WID-1:0]   rem,
    output logic             dbz
);

    localparam int CNTW = $clog2(WID);
    localparam logic [WID-1:0] MIN_VAL = {1'b1, {(WID-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic [WID:0]     prem_q, prem_d;
    logic [WID-1:0]   dvd_q, dvd_d;
    logic [WID-1:0]   dvs_q, dvs_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             res_v_q, res_v_d;
    logic [RNDXW-1:0] res_id_q, res_id_d;
    logic [PREGW-1:0] res_nrt_q, res_nrt_d;
    logic [WID-1:0]   quot_q, quot_d;
    logic [WID-1:0]   rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic             accept;
    logic             by_zero;
    logic             ovf;
    logic             last_step;
    logic [WID-1:0]   a_abs, b_abs;
    logic [WID:0]     shifted;
    logic             ge;
    logic [WID:0]     prem_nx;
    logic [WID-1:0]   dvd_nx;

    assign accept    = ld && div && !flush && (state_q == IDLE);
    assign by_zero   = (argB == '0);
    assign ovf       = sgn && (argA == MIN_VAL) && (argB == '1);
    assign last_step = (count_q == CNTW'(WID-1));
    assign a_abs     = (sgn && argA[WID-1]) ? -argA : argA;
    assign b_abs     = (sgn && argB[WID-1]) ? -argB : argB;

    // One restoring step; prem_q[WID] is only set if the remainder ever exceeded the divisor range.
    assign shifted = {prem_q[WID-1:0], dvd_q[WID-1]};
    assign ge      = prem_q[WID] || (shifted >= {1'b0, dvs_q});
    assign prem_nx = ge ? (shifted - {1'b0, dvs_q}) : shifted;
    assign dvd_nx  = {dvd_q[WID-2:0], ge};

    // State register: every flop in one place, reset synchronously.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
        if (!rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            prem_q    <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            res_v_q   <= 1'b0;
            res_id_q  <= '0;
            res_nrt_q <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            prem_q    <= prem_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            res_v_q   <= res_v_d;
            res_id_q  <= res_id_d;
            res_nrt_q <= res_nrt_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            dbz_q     <= dbz_d;
        end
    end

    // Next-state logic; flush overrides both ld and wr_ack.
    always_comb begin
        // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (accept) state_d = (by_zero || ovf) ? DONE : BUSY;
                BUSY:    if (last_step) state_d = DONE;
                DONE:    if (wr_ack) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath and result registers.
    always_comb begin
        count_d   = count_q;
        prem_d    = prem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        res_v_d   = res_v_q;
        res_id_d  = res_id_q;
        res_nrt_d = res_nrt_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        dbz_d     = dbz_q;
        if (flush) begin
            res_v_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        res_id_d  = id;
                        res_nrt_d = nRt;
                        qneg_d    = sgn && (argA[WID-1] ^ argB[WID-1]);
                        rneg_d    = sgn && argA[WID-1];
                        if (by_zero) begin
                            quot_d  = '1;
                            rem_d   = argA;
                            dbz_d   = 1'b1;
                            res_v_d = 1'b1;
                        end else if (ovf) begin
                            quot_d  = MIN_VAL;
                            rem_d   = '0;
                            dbz_d   = 1'b0;
                            res_v_d = 1'b1;
                        end else begin
                            count_d = '0;
                            prem_d  = '0;
                            dvd_d   = a_abs;
                            dvs_d   = b_abs;
                        end
                    end
                end
                BUSY: begin
                    prem_d  = prem_nx;
                    dvd_d   = dvd_nx;
                    count_d = count_q + 1'b1;
                    if (last_step) begin
                        quot_d  = qneg_q ? -dvd_nx : dvd_nx;
                        rem_d   = rneg_q ? -prem_nx[WID-1:0] : prem_nx[WID-1:0];
                        dbz_d   = 1'b0;
                        res_v_d = 1'b1;
                    end
                end
                DONE: begin
                    if (wr_ack) res_v_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Output logic: only idle is combinational.
    always_comb begin
        idle = (state_q == IDLE);
    end

    assign res_v   = res_v_q;
    assign res_id  = res_id_q;
    assign res_nRt = res_nrt_q;
    assign quot    = quot_q;
    assign rem     = rem_q;
    assign dbz     = dbz_q;

endmodule

// File: tb/tb_qupls_alu_div_seq.sv
// Scoreboard bench for qupls_alu_div_seq: directed divides, latency, special cases,
// flush mid-operation and extended hold in DONE.
module tb_qupls_alu_div_seq;

    localparam int WID   = 64;
    localparam int RNDXW = 5;
    localparam int PREGW = 11;

    logic             clk;
    logic             rst;
    logic             ld;
    logic             div;
    logic             sgn;
    logic [RNDXW-1:0] id;
    logic [PREGW-1:0] nRt;
    logic [WID-1:0]   argA;
    logic [WID-1:0]   argB;
    logic             flush;
    logic             wr_ack;
    logic             idle;
    logic             res_v;
    logic [RNDXW-1:0] res_id;
    logic [PREGW-1:0] res_nRt;
    logic [WID-1:0]   quot;
    logic [WID-1:0]   rem;
    logic             dbz;

    qupls_alu_div_seq #(.WID(WID), .RNDXW(RNDXW), .PREGW(PREGW)) dut (
        .clk(clk), .rst(rst), .ld(ld), .div(div), .sgn(sgn), .id(id), .nRt(nRt),
        .argA(argA), .argB(argB), .flush(flush), .wr_ack(wr_ack), .idle(idle),
        .res_v(res_v), .res_id(res_id), .res_nRt(res_nRt), .quot(quot), .rem(rem), .dbz(dbz)
    );

    typedef struct {
        logic [RNDXW-1:0] id;
        logic [PREGW-1:0] nrt;
        logic [WID-1:0]   q;
        logic [WID-1:0]   r;
        logic             dbz;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [WID-1:0] act, input logic [WID-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares each newly presented result against the head of the scoreboard.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (res_v === 1'b1 && !prev) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got res_v=1 id=%0d expected no result", res_id);
                end else begin
                    e = sb.pop_front();
                    check("latency_cycle", WID'(cyc), WID'(e.cyc));
                    check("res_id", WID'(res_id), WID'(e.id));
                    check("res_nRt", WID'(res_nRt), WID'(e.nrt));
                    check("quot", quot, e.q);
                    check("rem", rem, e.r);
                    check("dbz", WID'(dbz), WID'(e.dbz));
                end
            end
            prev = (res_v === 1'b1);
        end
    end

    // Drive one ld for a cycle; lat is the number of edges after the ld edge until res_v shows.
    task automatic issue(input logic [WID-1:0] a, input logic [WID-1:0] b, input logic s,
                         input logic [RNDXW-1:0] i, input logic [PREGW-1:0] n,
                         input logic [WID-1:0] eq, input logic [WID-1:0] er, input logic ed,
                         input int lat, input bit expect_res);
        exp_t e;
        @(negedge clk);
        ld = 1'b1; div = 1'b1; sgn = s; id = i; nRt = n; argA = a; argB = b;
        @(posedge clk);
        #1;
        ld = 1'b0;
        if (expect_res) begin
            e.id = i; e.nrt = n; e.q = eq; e.r = er; e.dbz = ed; e.cyc = cyc + lat;
            sb.push_back(e);
        end
    endtask

    task automatic wait_res(input int budget);
        bit got;
        got = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (res_v === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL res_v_timeout: got no res_v within %0d cycles expected res_v=1", budget);
        end
    endtask

    task automatic ack_and_check();
        wr_ack = 1'b1;
        @(posedge clk);
        #1;
        wr_ack = 1'b0;
        @(negedge clk);
        check("idle_after_ack", WID'(idle), WID'(1));
        check("res_v_after_ack", WID'(res_v), WID'(0));
    endtask

    task automatic run_op(input logic [WID-1:0] a, input logic [WID-1:0] b, input logic s,
                          input logic [RNDXW-1:0] i, input logic [PREGW-1:0] n,
                          input logic [WID-1:0] eq, input logic [WID-1:0] er, input logic ed,
                          input int lat);
        issue(a, b, s, i, n, eq, er, ed, lat, 1'b1);
        wait_res(lat + 8);
        ack_and_check();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got simulation still running expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; ld = 1'b0; div = 1'b0; sgn = 1'b0; id = '0; nRt = '0;
        argA = '0; argB = '0; flush = 1'b0; wr_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        check("rst_idle", WID'(idle), WID'(1));
        check("rst_res_v", WID'(res_v), WID'(0));
        check("rst_quot", quot, '0);
        check("rst_rem", rem, '0);
        check("rst_dbz", WID'(dbz), WID'(0));
        check("rst_res_id", WID'(res_id), WID'(0));
        check("rst_res_nRt", WID'(res_nRt), WID'(0));

        // ld with div=0 must be ignored.
        @(negedge clk);
        ld = 1'b1; div = 1'b0; argA = 64'd50; argB = 64'd5;
        @(posedge clk);
        #1;
        ld = 1'b0;
        @(negedge clk);
        check("div0_ignored_idle", WID'(idle), WID'(1));

        // flush beats ld in the same cycle.
        ld = 1'b1; div = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        ld = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_beats_ld_idle", WID'(idle), WID'(1));

        run_op(64'd100, 64'd7, 1'b0, 5'd3, 11'd100, 64'd14, 64'd2, 1'b0, WID);
        run_op(-64'd100, 64'd7, 1'b1, 5'd4, 11'd101, -64'd14, -64'd2, 1'b0, WID);
        run_op(64'd100, -64'd7, 1'b1, 5'd5, 11'd102, -64'd14, 64'd2, 1'b0, WID);
        run_op(-64'd7, -64'd2, 1'b1, 5'd6, 11'd103, 64'd3, -64'd1, 1'b0, WID);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1'b0, 5'd7, 11'd104,
               64'h5555_5555_5555_5555, 64'd0, 1'b0, WID);
        run_op(64'd7, 64'd100, 1'b0, 5'd8, 11'd105, 64'd0, 64'd7, 1'b0, WID);
        run_op(64'h1234, 64'd0, 1'b0, 5'd10, 11'd106, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1'b1, 0);
        run_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd11, 11'd107,
               64'h8000_0000_0000_0000, 64'd0, 1'b0, 0);

        // Flush 30 cycles into BUSY: unit returns to idle and no result appears.
        issue(64'd1000, 64'd3, 1'b0, 5'd12, 11'd200, '0, '0, 1'b0, WID, 1'b0);
        repeat (29) @(negedge clk);
        check("busy_before_flush", WID'(idle), WID'(0));
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_idle", WID'(idle), WID'(1));
        check("flush_res_v", WID'(res_v), WID'(0));
        repeat (WID + 10) @(negedge clk);
        run_op(64'd1000, 64'd3, 1'b0, 5'd13, 11'd201, 64'd333, 64'd1, 1'b0, WID);

        // Hold in DONE for 10 cycles while ld is asserted; outputs must not move.
        issue(64'd100, 64'd7, 1'b0, 5'd9, 11'd33, 64'd14, 64'd2, 1'b0, WID, 1'b1);
        wait_res(WID + 8);
        for (int k = 0; k < 10; k++) begin
            ld = 1'b1; div = 1'b1; sgn = 1'b0; id = 5'd1; nRt = 11'd1; argA = 64'd5; argB = 64'd1;
            @(posedge clk);
            @(negedge clk);
            check("hold_res_v", WID'(res_v), WID'(1));
            check("hold_idle", WID'(idle), WID'(0));
            check("hold_quot", quot, 64'd14);
            check("hold_rem", rem, 64'd2);
            check("hold_res_id", WID'(res_id), WID'(9));
        end
        ld = 1'b0;
        ack_and_check();

        repeat (4) @(negedge clk);
        check("scoreboard_empty", WID'(sb.size()), WID'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
